// File: rtl/uart_temp_report_tx.sv
// Multi-channel temperature reporter: snapshots signed fixed-point words, formats them as
// "Tk=sDDD.DC" ASCII fields separated by spaces and ending in CR LF, and sends the line over a UART.
module uart_temp_report_tx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 4,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       send,
  input  logic [CHANNELS*DATA_W-1:0] data,
  output logic                       ready,
  output logic                       done,
  output logic                       tx
);
  localparam int unsigned BaudDiv  = CLK_FREQ / BAUD;
  localparam int unsigned BaudW    = BaudDiv > 1 ? $clog2(BaudDiv) : 1;
  localparam int unsigned FieldLen = FRAC_BITS > 0 ? 10 : 8;
  localparam int unsigned PosW     = $clog2(FieldLen);
  localparam int unsigned ChW      = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [DATA_W-1:0] FracMask = DATA_W'((64'd1 << FRAC_BITS) - 64'd1);

  typedef enum logic [2:0] {
    StIdle, StConv, StStart, StData, StParity, StStop, StDone
  } state_e;

  state_e                     state_q, state_d;
  logic [CHANNELS*DATA_W-1:0] data_q, data_d;
  logic [ChW-1:0]             ch_q, ch_d, tx_ch_q, tx_ch_d;
  logic [3:0]                 step_q, step_d, pos_q, pos_d;
  logic [9:0]                 bin_q, bin_d;
  logic [11:0]                bcd_q, bcd_d;
  logic [3:0]                 tenths_q, tenths_d;
  logic                       sign_q, sign_d, par_q, par_d, tail_q, tail_d;
  logic                       abort_q, abort_d, stop_q, stop_d;
  logic [BaudW-1:0]           baud_q, baud_d;
  logic [2:0]                 bit_q, bit_d;
  logic [7:0]                 shreg_q, shreg_d;

  logic [7:0]        buf_q [CHANNELS][FieldLen];
  logic [7:0]        field [FieldLen];
  logic              buf_we;
  logic [DATA_W-1:0] word, mag;
  logic [31:0]       int_val;
  logic [3:0]        tenths_val;
  logic [7:0]        cur_char;
  logic              baud_end, last_char, accept;

  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == ChW'(k)) word = data_q[k*DATA_W +: DATA_W];
    end
  end

  // Unsigned magnitude: the most negative word maps to 2^(DATA_W-1) without overflow.
  assign mag        = word[DATA_W-1] ? (~word) + DATA_W'(1) : word;
  assign int_val    = 32'(mag >> FRAC_BITS);
  assign tenths_val = 4'((32'(mag & FracMask) * 32'd10) >> FRAC_BITS);

  assign field[0] = "T";
  assign field[1] = 8'h30 + 8'(ch_q);
  assign field[2] = "=";
  assign field[3] = sign_q ? "-" : "+";
  assign field[4] = {4'h3, bcd_q[11:8]};
  assign field[5] = {4'h3, bcd_q[7:4]};
  assign field[6] = {4'h3, bcd_q[3:0]};
  if (FRAC_BITS > 0) begin : g_frac
    assign field[7] = ".";
    assign field[8] = {4'h3, tenths_q};
    assign field[9] = "C";
  end else begin : g_int
    assign field[7] = "C";
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      for (int j = 0; j < FieldLen; j++) buf_q[ch_q][j] <= field[j];
    end
  end

  // Slot FieldLen of a channel is the separator; the tail holds CR then LF.
  always_comb begin
    cur_char = 8'h20;
    if (tail_q) cur_char = pos_q[0] ? 8'h0A : 8'h0D;
    else if (pos_q != 4'(FieldLen)) cur_char = buf_q[tx_ch_q][pos_q[PosW-1:0]];
  end

  assign ready     = (state_q == StIdle) || (state_q == StDone);
  assign done      = (state_q == StDone);
  assign accept    = send & en & ready;
  assign baud_end  = (baud_q == BaudW'(BaudDiv - 1));
  assign last_char = tail_q & pos_q[0];

  always_comb begin
    case (state_q)
      StStart:  tx = 1'b0;
      StData:   tx = shreg_q[0];
      StParity: tx = par_q;
      default:  tx = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    ch_d     = ch_q;
    step_d   = step_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    tenths_d = tenths_q;
    sign_d   = sign_q;
    par_d    = par_q;
    tail_d   = tail_q;
    abort_d  = abort_q;
    stop_d   = stop_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_ch_d  = tx_ch_q;
    pos_d    = pos_q;
    buf_we   = 1'b0;

    if (!en && (state_q inside {StStart, StData, StParity, StStop})) abort_d = 1'b1;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StConv;
          data_d  = data;
          ch_d    = '0;
          step_d  = '0;
          tx_ch_d = '0;
          pos_d   = '0;
          tail_d  = 1'b0;
          abort_d = 1'b0;
        end
      end
      StConv: begin
        if (!en) begin
          state_d = StIdle;
        end else if (step_q == 4'd0) begin
          sign_d = word[DATA_W-1];
          bcd_d  = '0;
          if (int_val > 32'd999) begin
            bin_d    = 10'd999;
            tenths_d = 4'd9;
          end else begin
            bin_d    = int_val[9:0];
            tenths_d = tenths_val;
          end
          step_d = 4'd1;
        end else if (step_q <= 4'd10) begin
          {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
          step_d = step_q + 4'd1;
        end else begin
          buf_we = 1'b1;
          step_d = '0;
          if (ch_q == ChW'(CHANNELS - 1)) begin
            state_d = StStart;
            baud_d  = '0;
          end else begin
            ch_d = ch_q + ChW'(1);
          end
        end
      end
      StStart: begin
        baud_d = baud_q + BaudW'(1);
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          shreg_d = cur_char;
          par_d   = (PARITY == 2) ? ~^cur_char : ^cur_char;
          state_d = StData;
        end
      end
      StData: begin
        baud_d = baud_q + BaudW'(1);
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        baud_d = baud_q + BaudW'(1);
        if (baud_end) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        baud_d = baud_q + BaudW'(1);
        if (baud_end) begin
          baud_d = '0;
          if (stop_q != 1'(STOP_BITS - 1)) begin
            stop_d = 1'b1;
          end else if (abort_q || !en) begin
            state_d = StIdle;
          end else if (last_char) begin
            state_d = StDone;
          end else begin
            state_d = StStart;
            if (tail_q) begin
              pos_d = 4'd1;
            end else if (pos_q == 4'(FieldLen - 1) && tx_ch_q == ChW'(CHANNELS - 1)) begin
              tail_d = 1'b1;
              pos_d  = '0;
            end else if (pos_q == 4'(FieldLen)) begin
              tx_ch_d = tx_ch_q + ChW'(1);
              pos_d   = '0;
            end else begin
              pos_d = pos_q + 4'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      ch_q     <= '0;
      step_q   <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      tenths_q <= '0;
      sign_q   <= 1'b0;
      par_q    <= 1'b0;
      tail_q   <= 1'b0;
      abort_q  <= 1'b0;
      stop_q   <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_ch_q  <= '0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      step_q   <= step_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      tenths_q <= tenths_d;
      sign_q   <= sign_d;
      par_q    <= par_d;
      tail_q   <= tail_d;
      abort_q  <= abort_d;
      stop_q   <= stop_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_ch_q  <= tx_ch_d;
      pos_q    <= pos_d;
    end
  end

endmodule
